// File: rtl/matmul_result_reader.sv
// Drain side of the matmul array: snapshots the packed C matrix and overflow flags on a
// capture strobe, then streams the valid N x M elements row-major over valid/ready.
module matmul_result_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic                                             capture_i,
  input  logic [1:0]                                       n_dim_i,
  input  logic [1:0]                                       m_dim_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2*2*DATA_WIDTH-1:0] c_matrix_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)**2-1:0]             flags_i,
  input  logic                                             rd_ready_i,
  output logic                                             rd_valid_o,
  output logic [2*DATA_WIDTH-1:0]                          rd_data_o,
  output logic [1:0]                                       rd_row_o,
  output logic [1:0]                                       rd_col_o,
  output logic                                             rd_ovf_o,
  output logic                                             rd_last_o,
  output logic                                             busy_o,
  output logic                                             done_o
);
  localparam int         MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int         EW      = 2 * DATA_WIDTH;
  localparam int         NE      = MAX_DIM * MAX_DIM;
  localparam logic [1:0] MAXD    = 2'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e            state_q, state_d;
  logic [NE*EW-1:0]  c_q, c_d;
  logic [NE-1:0]     f_q, f_d;
  logic [1:0]        n_q, n_d, m_q, m_d;
  logic [1:0]        row_q, row_d, col_q, col_d;

  logic              stream;
  logic              last;
  logic [3:0]        idx;
  logic [EW-1:0]     elem;
  logic              elem_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      c_q     <= '0;
      f_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      f_q     <= f_d;
      n_q     <= n_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign stream = (state_q == STREAM);
  assign last   = (row_q == n_q - 2'd1) && (col_q == m_q - 2'd1);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    f_d     = f_q;
    n_d     = n_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (capture_i) begin
          c_d   = c_matrix_i;
          f_d   = flags_i;
          n_d   = n_dim_i;
          m_d   = m_dim_i;
          row_d = '0;
          col_d = '0;
          // Degenerate or oversized shapes produce no beats, only the completion pulse
          if (n_dim_i == 2'd0 || m_dim_i == 2'd0 || n_dim_i > MAXD || m_dim_i > MAXD)
            state_d = DONE;
          else
            state_d = STREAM;
        end
      end
      STREAM: begin
        if (rd_ready_i) begin
          if (last) begin
            state_d = DONE;
            row_d   = '0;
            col_d   = '0;
          end else if (col_q == m_q - 2'd1) begin
            col_d = '0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot is column-major: element (row,col) lives in slot col*MAX_DIM+row
  always_comb begin
    idx      = 4'(col_q) * 4'(MAX_DIM) + 4'(row_q);
    elem     = '0;
    elem_ovf = 1'b0;
    for (int s = 0; s < NE; s++) begin
      if (idx == 4'(s)) begin
        elem     = c_q[s*EW +: EW];
        elem_ovf = f_q[s];
      end
    end
  end

  assign rd_valid_o = stream;
  assign rd_data_o  = stream ? elem : '0;
  assign rd_ovf_o   = stream & elem_ovf;
  assign rd_row_o   = stream ? row_q : 2'd0;
  assign rd_col_o   = stream ? col_q : 2'd0;
  assign rd_last_o  = stream & last;
  assign busy_o     = stream;
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_matmul_result_reader.sv
// Randomized bench for matmul_result_reader: a 2x2 instance and a 3x3 instance checked
// against a row-major stream model built from a plain 2-D matrix.
module tb_matmul_result_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cap2 = 1'b0, rdy2 = 1'b0;
  logic [1:0]  n2 = '0, m2 = '0;
  logic [63:0] cm2 = '0;
  logic [3:0]  fl2 = '0;
  logic        v2, o2, l2, b2, dn2;
  logic [15:0] d2;
  logic [1:0]  r2, c2;

  logic         cap3 = 1'b0, rdy3 = 1'b0;
  logic [1:0]   n3 = '0, m3 = '0;
  logic [143:0] cm3 = '0;
  logic [8:0]   fl3 = '0;
  logic         v3, o3, l3, b3, dn3;
  logic [15:0]  d3;
  logic [1:0]   r3, c3;

  matmul_result_reader #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .capture_i(cap2), .n_dim_i(n2), .m_dim_i(m2),
    .c_matrix_i(cm2), .flags_i(fl2), .rd_ready_i(rdy2), .rd_valid_o(v2),
    .rd_data_o(d2), .rd_row_o(r2), .rd_col_o(c2), .rd_ovf_o(o2), .rd_last_o(l2),
    .busy_o(b2), .done_o(dn2));

  matmul_result_reader #(.DATA_WIDTH(8), .BUS_WIDTH(24)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .capture_i(cap3), .n_dim_i(n3), .m_dim_i(m3),
    .c_matrix_i(cm3), .flags_i(fl3), .rd_ready_i(rdy3), .rd_valid_o(v3),
    .rd_data_o(d3), .rd_row_o(r3), .rd_col_o(c3), .rd_ovf_o(o3), .rd_last_o(l3),
    .busy_o(b3), .done_o(dn3));

  // Reference model: the matrix as the producer sees it, C[row][col]
  logic [15:0] C [3][3];
  logic        F [3][3];
  int ncmp = 0;
  int nerr = 0;

  task automatic rand_mat();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        C[r][c] = 16'($urandom);
        F[r][c] = 1'($urandom);
      end
  endtask

  task automatic pack();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        cm3[(c*3+r)*16 +: 16] = C[r][c];
        fl3[c*3+r]            = F[r][c];
        if (r < 2 && c < 2) begin
          cm2[(c*2+r)*16 +: 16] = C[r][c];
          fl2[c*2+r]            = F[r][c];
        end
      end
  endtask

  function automatic logic [22:0] exp_beat(int k, int n, int m);
    int r, c;
    r = k / m;
    c = k % m;
    return {1'b1, 2'(r), 2'(c), C[r][c], F[r][c], 1'(k == n*m-1)};
  endfunction

  task automatic capture2(input logic [1:0] n, input logic [1:0] m);
    @(posedge clk); #1;
    n2 = n; m2 = m; cap2 = 1'b1;
    @(posedge clk); #1;
    cap2 = 1'b0;
  endtask

  task automatic capture3(input logic [1:0] n, input logic [1:0] m);
    @(posedge clk); #1;
    n3 = n; m3 = m; cap3 = 1'b1;
    @(posedge clk); #1;
    cap3 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    ncmp++;
    if ({v2, d2, r2, c2, o2, l2, b2, dn2} !== 24'h0 || {v3, d3, r3, c3, o3, l3, b3, dn3} !== 24'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got %h / %h want 0", {v2, d2, r2, c2, o2, l2, b2, dn2},
               {v3, d3, r3, c3, o3, l3, b3, dn3});
    end
    #7 rst_n = 1'b1;
  endtask

  task automatic test_full_rate();
    int n, m;
    for (int it = 0; it < 6; it++) begin
      rand_mat();
      if (it == 0) begin
        C[0][0] = 16'd1; C[0][1] = 16'd2; C[1][0] = 16'd3; C[1][1] = 16'd4;
        F[0][0] = 0; F[0][1] = 0; F[1][0] = 0; F[1][1] = 0;
        n = 2; m = 2;
      end else if (it == 1) begin
        C[0][0] = 16'hFFFB;
        F[0][0] = 0; F[0][1] = 1; F[1][0] = 0; F[1][1] = 0;
        n = 1; m = 2;
      end else begin
        n = $urandom_range(1, 2);
        m = $urandom_range(1, 2);
      end
      rdy2 = 1'b1;
      pack();
      capture2(2'(n), 2'(m));
      for (int k = 0; k < n*m; k++) begin
        @(negedge clk);
        ncmp++;
        if ({v2, r2, c2, d2, o2, l2} !== exp_beat(k, n, m)) begin
          nerr++;
          $display("FAIL full_rate_beat it%0d k%0d: got %h want %h", it, k,
                   {v2, r2, c2, d2, o2, l2}, exp_beat(k, n, m));
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      ncmp++;
      if ({dn2, b2, v2} !== 3'b100) begin
        nerr++;
        $display("FAIL full_rate_done it%0d: got %b want 100", it, {dn2, b2, v2});
      end
      @(negedge clk);
      ncmp++;
      if ({dn2, b2, v2} !== 3'b000) begin
        nerr++;
        $display("FAIL full_rate_idle it%0d: got %b want 000", it, {dn2, b2, v2});
      end
    end
  endtask

  task automatic test_backpressure();
    int n, m, k, cyc;
    for (int it = 0; it < 6; it++) begin
      rand_mat();
      n = (it == 0) ? 2 : $urandom_range(1, 2);
      m = (it == 0) ? 2 : $urandom_range(1, 2);
      pack();
      rdy2 = 1'b1;
      capture2(2'(n), 2'(m));
      k = 0; cyc = 0;
      while (k < n*m && cyc < 100) begin
        @(negedge clk);
        ncmp++;
        if ({v2, r2, c2, d2, o2, l2} !== exp_beat(k, n, m)) begin
          nerr++;
          $display("FAIL stall_beat it%0d k%0d: got %h want %h", it, k,
                   {v2, r2, c2, d2, o2, l2}, exp_beat(k, n, m));
        end
        if (rdy2) k++;
        @(posedge clk); #1;
        rdy2 = (it == 0) ? 1'((cyc % 3) != 0) : 1'($urandom);
        cyc++;
      end
      ncmp++;
      if (k != n*m) begin
        nerr++;
        $display("FAIL stall_timeout it%0d: got %0d beats want %0d", it, k, n*m);
      end
      @(negedge clk);
      ncmp++;
      if ({dn2, b2, v2} !== 3'b100) begin
        nerr++;
        $display("FAIL stall_done it%0d: got %b want 100", it, {dn2, b2, v2});
      end
    end
    rdy2 = 1'b1;
  endtask

  task automatic test_recapture_ignored();
    rand_mat();
    pack();
    rdy2 = 1'b1;
    capture2(2'd2, 2'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ncmp++;
      if ({v2, r2, c2, d2, o2, l2} !== exp_beat(k, 2, 2)) begin
        nerr++;
        $display("FAIL recapture_beat k%0d: got %h want %h", k, {v2, r2, c2, d2, o2, l2},
                 exp_beat(k, 2, 2));
      end
      @(posedge clk); #1;
      if (k == 0) begin
        cm2 = {$urandom, $urandom};
        fl2 = ~fl2;
        n2 = 2'd1; m2 = 2'd1;
        cap2 = 1'b1;
      end else begin
        cap2 = 1'b0;
      end
    end
    @(negedge clk);
    ncmp++;
    if ({dn2, b2, v2} !== 3'b100) begin
      nerr++;
      $display("FAIL recapture_done: got %b want 100", {dn2, b2, v2});
    end
    @(negedge clk);
    ncmp++;
    if ({dn2, b2, v2} !== 3'b000) begin
      nerr++;
      $display("FAIL recapture_no_restart: got %b want 000", {dn2, b2, v2});
    end
  endtask

  task automatic test_reset_midstream();
    rand_mat();
    pack();
    rdy2 = 1'b1;
    capture2(2'd2, 2'd2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ncmp++;
      if ({v2, r2, c2, d2, o2, l2} !== exp_beat(k, 2, 2)) begin
        nerr++;
        $display("FAIL midrst_beat k%0d: got %h want %h", k, {v2, r2, c2, d2, o2, l2},
                 exp_beat(k, 2, 2));
      end
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    ncmp++;
    if ({v2, d2, r2, c2, o2, l2, b2, dn2} !== 24'h0) begin
      nerr++;
      $display("FAIL midrst_clear: got %h want 0", {v2, d2, r2, c2, o2, l2, b2, dn2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({dn2, b2, v2} !== 3'b000) begin
      nerr++;
      $display("FAIL midrst_no_done: got %b want 000", {dn2, b2, v2});
    end
    rand_mat();
    pack();
    capture2(2'd2, 2'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ncmp++;
      if ({v2, r2, c2, d2, o2, l2} !== exp_beat(k, 2, 2)) begin
        nerr++;
        $display("FAIL postrst_beat k%0d: got %h want %h", k, {v2, r2, c2, d2, o2, l2},
                 exp_beat(k, 2, 2));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    ncmp++;
    if ({dn2, b2, v2} !== 3'b100) begin
      nerr++;
      $display("FAIL postrst_done: got %b want 100", {dn2, b2, v2});
    end
  endtask

  task automatic test_bad_dims();
    logic [3:0] shapes [5];
    shapes = '{4'b00_10, 4'b10_00, 4'b11_01, 4'b01_11, 4'b00_00};
    rdy2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_mat();
      pack();
      capture2(shapes[i][3:2], shapes[i][1:0]);
      @(negedge clk);
      ncmp++;
      if ({dn2, b2, v2} !== 3'b100) begin
        nerr++;
        $display("FAIL baddim_done n%0d m%0d: got %b want 100", shapes[i][3:2], shapes[i][1:0],
                 {dn2, b2, v2});
      end
      @(negedge clk);
      ncmp++;
      if ({dn2, b2, v2} !== 3'b000) begin
        nerr++;
        $display("FAIL baddim_idle n%0d m%0d: got %b want 000", shapes[i][3:2], shapes[i][1:0],
                 {dn2, b2, v2});
      end
    end
  endtask

  task automatic test_dim3();
    int n, m, k, cyc;
    for (int it = 0; it < 4; it++) begin
      rand_mat();
      n = (it < 2) ? 3 : $urandom_range(1, 3);
      m = (it < 2) ? 3 : $urandom_range(1, 3);
      pack();
      rdy3 = 1'b1;
      capture3(2'(n), 2'(m));
      k = 0; cyc = 0;
      while (k < n*m && cyc < 200) begin
        @(negedge clk);
        ncmp++;
        if ({v3, r3, c3, d3, o3, l3} !== exp_beat(k, n, m)) begin
          nerr++;
          $display("FAIL dim3_beat it%0d k%0d: got %h want %h", it, k,
                   {v3, r3, c3, d3, o3, l3}, exp_beat(k, n, m));
        end
        if (rdy3) k++;
        @(posedge clk); #1;
        rdy3 = (it == 0) ? 1'b1 : 1'($urandom);
        cyc++;
      end
      ncmp++;
      if (k != n*m) begin
        nerr++;
        $display("FAIL dim3_timeout it%0d: got %0d beats want %0d", it, k, n*m);
      end
      @(negedge clk);
      ncmp++;
      if ({dn3, b3, v3} !== 3'b100) begin
        nerr++;
        $display("FAIL dim3_done it%0d: got %b want 100", it, {dn3, b3, v3});
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_recapture_ignored();
    test_reset_midstream();
    test_bad_dims();
    test_dim3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
